// File: rtl/mem_arb_pkg.sv
// Shared types for the unified program/data memory port arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      RETURN = 2'd2
   } state_e;

   localparam logic REQ_I = 1'b0;
   localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin winner select; purely combinational.
module rr_arbiter2
   import mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_served,
   output logic [1:0] gnt,
   output logic       valid
);

   always_comb begin
      gnt   = 2'b00;
      valid = |req;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         // On a tie the requester not served last wins
         2'b11:   gnt = (last_served == REQ_D) ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between the fetch and load/store paths,
// issuing registered RAM commands and routing read data back to the owner.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_req,
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic                  i_gnt,
   output logic                  i_rvalid,
   output logic [DATA_WIDTH-1:0] i_rdata,
   input  logic                  d_req,
   input  logic                  d_we,
   input  logic [ADDR_WIDTH-1:0] d_addr,
   input  logic [DATA_WIDTH-1:0] d_wdata,
   output logic                  d_gnt,
   output logic                  d_rvalid,
   output logic [DATA_WIDTH-1:0] d_rdata,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  busy
);

   state_e                state_q, state_d;
   logic                  last_served_q, last_served_d;
   logic                  owner_q, owner_d;
   logic                  i_gnt_q, i_gnt_d;
   logic                  d_gnt_q, d_gnt_d;
   logic                  mem_en_q, mem_en_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

   logic [1:0] arb_gnt;
   logic       arb_valid;
   logic       accept;

   rr_arbiter2 u_arb (
      .req         ({d_req, i_req}),
      .last_served (last_served_q),
      .gnt         (arb_gnt),
      .valid       (arb_valid)
   );

   always_comb begin
      state_d       = state_q;
      last_served_d = last_served_q;
      owner_d       = owner_q;
      i_gnt_d       = 1'b0;
      d_gnt_d       = 1'b0;
      mem_en_d      = 1'b0;
      mem_we_d      = 1'b0;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      accept        = 1'b0;

      case (state_q)
         IDLE, RETURN: begin
            accept  = arb_valid;
            state_d = IDLE;
         end
         // The command is on the RAM this cycle; only reads need a return slot
         ISSUE:   state_d = mem_we_q ? IDLE : RETURN;
         default: state_d = IDLE;
      endcase

      if (accept) begin
         state_d       = ISSUE;
         owner_d       = arb_gnt[1] ? REQ_D : REQ_I;
         last_served_d = arb_gnt[1] ? REQ_D : REQ_I;
         i_gnt_d       = arb_gnt[0];
         d_gnt_d       = arb_gnt[1];
         mem_en_d      = 1'b1;
         if (arb_gnt[1]) begin
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
         end else begin
            mem_addr_d  = i_addr;
            mem_wdata_d = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         last_served_q <= REQ_D;
         owner_q       <= REQ_I;
         i_gnt_q       <= 1'b0;
         d_gnt_q       <= 1'b0;
         mem_en_q      <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
      end else begin
         state_q       <= state_d;
         last_served_q <= last_served_d;
         owner_q       <= owner_d;
         i_gnt_q       <= i_gnt_d;
         d_gnt_q       <= d_gnt_d;
         mem_en_q      <= mem_en_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
      end
   end

   assign i_gnt     = i_gnt_q;
   assign d_gnt     = d_gnt_q;
   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = (state_q != IDLE);

   // RAM read data arrives during RETURN and passes straight to the owner
   assign i_rvalid = (state_q == RETURN) && (owner_q == REQ_I);
   assign d_rvalid = (state_q == RETURN) && (owner_q == REQ_D);
   assign i_rdata  = i_rvalid ? mem_rdata : '0;
   assign d_rdata  = d_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural single-port RAM.
module tb_mem_port_arbiter;

   logic        clk;
   logic        reset;
   logic        i_req;
   logic [7:0]  i_addr;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [7:0]  d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        mem_en;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        busy;

   logic [31:0] ram [0:255];
   logic        pl_en;
   logic [7:0]  pl_addr;
   logic [31:0] pl_data;

   int n_checks;
   int n_fail;

   mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_gnt     (i_gnt),
      .i_rvalid  (i_rvalid),
      .i_rdata   (i_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_gnt     (d_gnt),
      .d_rvalid  (d_rvalid),
      .d_rdata   (d_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous RAM: read data valid the cycle after the read command
   always @(posedge clk) begin
      if (pl_en) ram[pl_addr] <= pl_data;
      else if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata     <= ram[mem_addr];
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic preload(input logic [7:0] a, input logic [31:0] v);
      pl_en = 1'b1; pl_addr = a; pl_data = v;
      step();
      pl_en = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
      step();
   endtask

   task automatic test_reset();
      reset = 1'b0; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
      pl_en = 0; pl_addr = 0; pl_data = 0; mem_rdata = 0;
      step();
      preload(8'h04, 32'hDEADBEEF);
      preload(8'hFF, 32'h11111111);
      n_checks++;
      if ({i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en, mem_we, busy} !== 7'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b want 0000000", {i_gnt, d_gnt, i_rvalid, d_rvalid, mem_en, mem_we, busy});
      end
      n_checks++;
      if ({mem_addr, mem_wdata, i_rdata, d_rdata} !== 104'b0) begin
         n_fail++;
         $display("FAIL reset_data: got %h %h %h %h want all 0", mem_addr, mem_wdata, i_rdata, d_rdata);
      end
      reset = 1'b1;
      step();
   endtask

   task automatic test_fetch_read();
      i_req = 1; i_addr = 8'h04;
      step();
      i_req = 0;
      n_checks++;
      if ({i_gnt, d_gnt, mem_en, mem_we, busy} !== 5'b10101) begin
         n_fail++;
         $display("FAIL t1_issue: got gnt_i/gnt_d/en/we/busy=%b want 10101", {i_gnt, d_gnt, mem_en, mem_we, busy});
      end
      n_checks++;
      if (mem_addr !== 8'h04) begin
         n_fail++; $display("FAIL t1_addr: got %h want 04", mem_addr);
      end
      step();
      n_checks++;
      if ({i_rvalid, d_rvalid, i_gnt, mem_en} !== 4'b1000 || i_rdata !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL t1_return: got rv_i/rv_d/gnt/en=%b rdata=%h want 1000 deadbeef", {i_rvalid, d_rvalid, i_gnt, mem_en}, i_rdata);
      end
      step();
      n_checks++;
      if ({busy, i_rvalid} !== 2'b00 || i_rdata !== 32'h0) begin
         n_fail++; $display("FAIL t1_idle: got busy=%b rv=%b rdata=%h want 0 0 0", busy, i_rvalid, i_rdata);
      end
   endtask

   task automatic test_write_read();
      d_req = 1; d_we = 1; d_addr = 8'h10; d_wdata = 32'h12345678;
      step();
      d_req = 0;
      n_checks++;
      if ({d_gnt, i_gnt, mem_en, mem_we} !== 4'b1011 || mem_wdata !== 32'h12345678 || mem_addr !== 8'h10) begin
         n_fail++;
         $display("FAIL t2_wr_issue: got gnt_d/gnt_i/en/we=%b addr=%h wdata=%h want 1011 10 12345678", {d_gnt, i_gnt, mem_en, mem_we}, mem_addr, mem_wdata);
      end
      d_req = 1; d_we = 0;
      step();
      n_checks++;
      if ({mem_we, mem_en, busy, d_gnt, d_rvalid} !== 5'b00000) begin
         n_fail++; $display("FAIL t2_we_one_cycle: got we/en/busy/gnt/rv=%b want 00000", {mem_we, mem_en, busy, d_gnt, d_rvalid});
      end
      step();
      d_req = 0;
      n_checks++;
      if ({d_gnt, mem_en, mem_we} !== 3'b110) begin
         n_fail++; $display("FAIL t2_rd_issue: got gnt/en/we=%b want 110", {d_gnt, mem_en, mem_we});
      end
      step();
      n_checks++;
      if ({d_rvalid, i_rvalid} !== 2'b10 || d_rdata !== 32'h12345678 || i_rdata !== 32'h0) begin
         n_fail++; $display("FAIL t2_rd_return: got rv_d/rv_i=%b d_rdata=%h i_rdata=%h want 10 12345678 0", {d_rvalid, i_rvalid}, d_rdata, i_rdata);
      end
      step();
   endtask

   task automatic test_tie_alternate();
      do_reset();
      i_req = 1; i_addr = 8'h04;
      d_req = 1; d_we = 0; d_addr = 8'h10;
      for (int k = 0; k < 8; k++) begin
         step();
         n_checks++;
         if ({i_gnt, d_gnt} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
            n_fail++; $display("FAIL t3_gnt%0d: got i/d=%b want %b", k, {i_gnt, d_gnt}, (k % 2 == 0) ? 2'b10 : 2'b01);
         end
         if (k == 7) begin
            i_req = 0; d_req = 0;
         end
         step();
         n_checks++;
         if (k % 2 == 0) begin
            if ({i_rvalid, d_rvalid, i_gnt, d_gnt} !== 4'b1000 || i_rdata !== 32'hDEADBEEF) begin
               n_fail++; $display("FAIL t3_ret%0d: got rv/gnt=%b rdata=%h want 1000 deadbeef", k, {i_rvalid, d_rvalid, i_gnt, d_gnt}, i_rdata);
            end
         end else begin
            if ({i_rvalid, d_rvalid, i_gnt, d_gnt} !== 4'b0100 || d_rdata !== 32'h12345678) begin
               n_fail++; $display("FAIL t3_ret%0d: got rv/gnt=%b rdata=%h want 0100 12345678", k, {i_rvalid, d_rvalid, i_gnt, d_gnt}, d_rdata);
            end
         end
      end
      step();
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL t3_idle: got busy=%b want 0", busy);
      end
   endtask

   task automatic test_accept_in_return();
      i_req = 1; i_addr = 8'h04;
      step();
      i_req = 0;
      d_req = 1; d_we = 1; d_addr = 8'h20; d_wdata = 32'hAAAA5555;
      step();
      n_checks++;
      if ({i_rvalid, d_gnt} !== 2'b10 || i_rdata !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL t4_return: got rv_i/gnt_d=%b rdata=%h want 10 deadbeef", {i_rvalid, d_gnt}, i_rdata);
      end
      step();
      d_req = 0;
      n_checks++;
      if ({d_gnt, mem_en, mem_we, busy} !== 4'b1111 || mem_addr !== 8'h20 || i_rvalid !== 1'b0) begin
         n_fail++; $display("FAIL t4_back_to_back: got gnt/en/we/busy=%b addr=%h rv_i=%b want 1111 20 0", {d_gnt, mem_en, mem_we, busy}, mem_addr, i_rvalid);
      end
      step();
      n_checks++;
      if (ram[8'h20] !== 32'hAAAA5555 || busy !== 1'b0) begin
         n_fail++; $display("FAIL t4_write_landed: got ram=%h busy=%b want aaaa5555 0", ram[8'h20], busy);
      end
   endtask

   task automatic test_async_reset();
      d_req = 1; d_we = 0; d_addr = 8'h10;
      step();
      n_checks++;
      if ({mem_en, busy, d_gnt} !== 3'b111) begin
         n_fail++; $display("FAIL t5_issue: got en/busy/gnt=%b want 111", {mem_en, busy, d_gnt});
      end
      #2;
      reset = 1'b0;
      #1;
      n_checks++;
      if ({mem_en, busy, d_gnt} !== 3'b000) begin
         n_fail++; $display("FAIL t5_async: got en/busy/gnt=%b want 000", {mem_en, busy, d_gnt});
      end
      d_req = 0;
      step();
      n_checks++;
      if ({d_rvalid, i_rvalid, busy, mem_en} !== 4'b0000 || d_rdata !== 32'h0) begin
         n_fail++; $display("FAIL t5_no_rvalid: got rv_d/rv_i/busy/en=%b rdata=%h want 0000 0", {d_rvalid, i_rvalid, busy, mem_en}, d_rdata);
      end
      reset = 1'b1;
      step();
      i_req = 1; i_addr = 8'h04;
      step();
      i_req = 0;
      n_checks++;
      if ({i_gnt, mem_en} !== 2'b11) begin
         n_fail++; $display("FAIL t5_fresh_gnt: got gnt/en=%b want 11", {i_gnt, mem_en});
      end
      step();
      n_checks++;
      if (i_rvalid !== 1'b1 || i_rdata !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL t5_fresh_data: got rv=%b rdata=%h want 1 deadbeef", i_rvalid, i_rdata);
      end
      step();
   endtask

   task automatic test_write_before_fetch();
      d_req = 1; d_we = 1; d_addr = 8'hFF; d_wdata = 32'hCAFEF00D;
      i_req = 1; i_addr = 8'hFF;
      step();
      d_req = 0;
      n_checks++;
      if ({d_gnt, i_gnt, mem_we} !== 3'b101 || mem_addr !== 8'hFF) begin
         n_fail++; $display("FAIL t6_write_first: got gnt_d/gnt_i/we=%b addr=%h want 101 ff", {d_gnt, i_gnt, mem_we}, mem_addr);
      end
      step();
      n_checks++;
      if ({busy, i_gnt, mem_en} !== 3'b000) begin
         n_fail++; $display("FAIL t6_gap: got busy/gnt/en=%b want 000", {busy, i_gnt, mem_en});
      end
      step();
      i_req = 0;
      n_checks++;
      if ({i_gnt, d_gnt, mem_we} !== 3'b100) begin
         n_fail++; $display("FAIL t6_fetch_gnt: got gnt_i/gnt_d/we=%b want 100", {i_gnt, d_gnt, mem_we});
      end
      step();
      n_checks++;
      if (i_rvalid !== 1'b1 || i_rdata !== 32'hCAFEF00D) begin
         n_fail++; $display("FAIL t6_fetch_data: got rv=%b rdata=%h want 1 cafef00d", i_rvalid, i_rdata);
      end
      step();
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_fetch_read();
      test_write_read();
      test_tie_alternate();
      test_accept_in_return();
      test_async_reset();
      test_write_before_fetch();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
